// File: rtl/axi4_master_port_if.sv
// AXI4 master-side bus bundle (AR/R/AW/W/B) for axi4_master_port.
// The master modport drives address/write channels and the R/B readies; the slave modport is its mirror.
interface axi4_master_port_if;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_master_port.sv
// Single-outstanding AXI4 master: one read or write INCR burst per request, one completion pulse each.
// Build macro AXI_MASTER_TIMEOUT_EN adds a per-wait-state watchdog forcing an error completion.
module axi4_master_port #(
  parameter logic [3:0] AXI_ID  = 4'd0,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  // All handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a source never withdraws valid or changes its payload before that edge.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic        wbeat_valid,
  output logic        wbeat_ready,
  input  logic [63:0] wbeat_data,
  input  logic [7:0]  wbeat_strb,
  output logic        rbeat_valid,
  input  logic        rbeat_ready,
  output logic [63:0] rbeat_data,
  output logic        rbeat_last,
  output logic        done_valid,
  output logic        done_err,
  output logic [2:0]  dbg_state,
  axi4_master_port_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        bready_q, bready_d;
  logic        done_valid_q, done_valid_d;
  logic        done_err_q, done_err_d;

  logic last_beat, r_hs, w_hs;

  assign last_beat = (cnt_q == len_q);
  assign r_hs      = (state_q == S_RDATA) && axi.rvalid && rbeat_ready;
  assign w_hs      = (state_q == S_WDATA) && wbeat_valid && axi.wready;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             waiting, any_hs;

  assign waiting = (state_q == S_RADDR) || (state_q == S_RDATA) || (state_q == S_WADDR) ||
                   (state_q == S_WDATA) || (state_q == S_WRESP);
  assign any_hs  = ((state_q == S_RADDR) && axi.arready) || r_hs ||
                   ((state_q == S_WADDR) && axi.awready) || w_hs ||
                   ((state_q == S_WRESP) && axi.bvalid);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          len_d   = req_len;
          size_d  = req_size;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = req_write ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: if (axi.arready) state_d = S_RDATA;
      S_RDATA: begin
        if (r_hs) begin
          // rlast must coincide exactly with beat == len; either mismatch is a protocol error
          if ((axi.rresp != 2'b00) || (axi.rid != AXI_ID) || (axi.rlast != last_beat))
            err_d = 1'b1;
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_WADDR: if (axi.awready) state_d = S_WDATA;
      S_WDATA: begin
        if (w_hs) begin
          if (last_beat) state_d = S_WRESP;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_WRESP: begin
        if (axi.bvalid) begin
          if ((axi.bresp != 2'b00) || (axi.bid != AXI_ID)) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    tmo_d = '0;
    if (waiting && !any_hs) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // Handshake outputs are registered from the next state so they change cleanly on the edge
    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_RADDR);
    awvalid_d    = (state_d == S_WADDR);
    bready_d     = (state_d == S_WRESP);
    done_valid_d = (state_d == S_DONE);
    done_err_d   = (state_d == S_DONE) && err_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      len_q        <= 8'd0;
      size_q       <= 3'd0;
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign done_valid  = done_valid_q;
  assign done_err    = done_err_q;
  assign dbg_state   = state_q;

  // The slave does the address incrementing for INCR bursts, so the start address is held as-is
  assign axi.araddr  = addr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'h0;
  assign axi.arprot  = 3'h0;
  assign axi.arvalid = arvalid_q;

  assign axi.awaddr  = addr_q;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'h0;
  assign axi.awprot  = 3'h0;
  assign axi.awvalid = awvalid_q;

  // R and W beats pass straight through while their data state is active
  assign axi.rready  = (state_q == S_RDATA) && rbeat_ready;
  assign rbeat_valid = (state_q == S_RDATA) && axi.rvalid;
  assign rbeat_data  = axi.rdata;
  assign rbeat_last  = (state_q == S_RDATA) && axi.rlast;

  assign axi.wvalid  = (state_q == S_WDATA) && wbeat_valid;
  assign wbeat_ready = (state_q == S_WDATA) && axi.wready;
  assign axi.wdata   = wbeat_data;
  assign axi.wstrb   = wbeat_strb;
  assign axi.wlast   = last_beat;
  assign axi.wid     = AXI_ID;

  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi4_master_port.sv
// Bench for axi4_master_port: directed vector table, corner sequences, then randomized bursts
// whose completion status comes from a beat-list reference model.
module tb_axi4_master_port;
  localparam logic [3:0] AXI_ID = 4'd0;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        wbeat_valid, wbeat_ready;
  logic [63:0] wbeat_data;
  logic [7:0]  wbeat_strb;
  logic        rbeat_valid, rbeat_ready;
  logic [63:0] rbeat_data;
  logic        rbeat_last;
  logic        done_valid, done_err;
  logic [2:0]  dbg_state;

  axi4_master_port_if axi();

  axi4_master_port #(.AXI_ID(AXI_ID), .TIMEOUT(TB_TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready),
    .wbeat_data(wbeat_data), .wbeat_strb(wbeat_strb),
    .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready),
    .rbeat_data(rbeat_data), .rbeat_last(rbeat_last),
    .done_valid(done_valid), .done_err(done_err),
    .dbg_state(dbg_state),
    .axi(axi)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    axi.arready = 1'b0; axi.awready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0; axi.rlast = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
  endtask

  // Returns at posedge+2 of the first cycle after the accepting edge.
  task automatic send_req(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_size = s;
    #1;
    for (int t = 0; t < 20 && !req_ready; t++) begin
      @(posedge clock); #2;
    end
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    #1;
    check("req_ready_busy", req_ready, 1'b0);
  endtask

  // inj_kind: 0 none, 1 rresp=SLVERR, 2 rlast forced on inj_beat, 3 foreign rid, 4 rlast missing on final beat
  // rmode: 0 always ready, 1 toggle each cycle, 2 random. exp_err < 0 selects the reference model.
  task automatic do_read(input string nm, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int inj_kind, input int inj_beat,
                         input int exp_err, input int rmode, input int stall,
                         input bit fix_d0, input logic [63:0] d0);
    logic [63:0] dq[$];
    logic [1:0]  rs[$];
    logic [3:0]  ids[$];
    logic        ls[$];
    int b, k;
    bit hs, e;
    for (int i = 0; i <= int'(len); i++) begin
      dq.push_back((fix_d0 && i == 0) ? d0 : {$urandom, $urandom});
      rs.push_back((inj_kind == 1 && i == inj_beat) ? 2'd2 : 2'd0);
      ids.push_back((inj_kind == 3 && i == inj_beat) ? 4'd5 : AXI_ID);
      ls.push_back((inj_kind == 2 && i == inj_beat) ? 1'b1 :
                   (inj_kind == 4 && i == int'(len)) ? 1'b0 : (i == int'(len)));
    end
    // reference: an error completion iff some beat is non-OKAY, foreign, or has rlast misplaced
    e = 1'b0;
    for (int i = 0; i <= int'(len); i++)
      if (rs[i] != 2'd0 || ids[i] != AXI_ID || ls[i] != (i == int'(len))) e = 1'b1;
    if (exp_err >= 0) e = (exp_err != 0);
    exp_q.delete();
    foreach (dq[i]) exp_q.push_back(dq[i]);

    send_req(1'b0, addr, len, size);
    check({nm, "_arvalid"}, axi.arvalid, 1'b1);
    check({nm, "_araddr"},  axi.araddr, addr);
    check({nm, "_arlen"},   axi.arlen, len);
    check({nm, "_arsize"},  axi.arsize, size);
    check({nm, "_arburst"}, axi.arburst, 2'b01);
    check({nm, "_arid"},    axi.arid, AXI_ID);
    check({nm, "_ar_tied"}, {axi.arlock, axi.arcache, axi.arprot}, 9'd0);
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #2;
      check({nm, "_ar_hold"}, {axi.arvalid, axi.araddr}, {1'b1, addr});
    end
    axi.arready = 1'b1;
    @(posedge clock); #1;
    axi.arready = 1'b0;

    b = 0;
    rbeat_ready = 1'b0;
    for (int cyc = 0; cyc < 3000 && b <= int'(len); cyc++) begin
      if (!axi.rvalid) axi.rvalid = ($urandom_range(0, stall) == 0);
      axi.rdata = dq[b]; axi.rresp = rs[b]; axi.rid = ids[b]; axi.rlast = ls[b];
      case (rmode)
        0:       rbeat_ready = 1'b1;
        1:       rbeat_ready = !rbeat_ready;
        default: rbeat_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check({nm, "_rbeat_valid"}, rbeat_valid, axi.rvalid);
      check({nm, "_rready"}, axi.rready, rbeat_ready);
      check({nm, "_no_early_done"}, done_valid, 1'b0);
      hs = axi.rvalid && rbeat_ready;
      if (hs) begin
        check({nm, "_rbeat_data"}, rbeat_data, exp_q.pop_front());
        check({nm, "_rbeat_last"}, rbeat_last, ls[b]);
      end
      @(posedge clock); #1;
      if (hs) begin
        b++;
        axi.rvalid = 1'b0;
      end
    end
    check({nm, "_r_beats"}, b, int'(len) + 1);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rbeat_ready = 1'b0;
    #1;
    check({nm, "_done_valid"}, done_valid, 1'b1);
    check({nm, "_done_err"}, done_err, e);
    @(posedge clock); #2;
    check({nm, "_done_pulse"}, done_valid, 1'b0);
    check({nm, "_back_idle"}, req_ready, 1'b1);
  endtask

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] bresp, input logic [3:0] bid,
                          input int exp_err, input int stall, input bit fix_strb);
    logic [63:0] wd[$];
    logic [7:0]  ws[$];
    int b, k;
    bit hs, e;
    for (int i = 0; i <= int'(len); i++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back((fix_strb && i == 0) ? 8'hFF : (fix_strb && i == 1) ? 8'h0F :
                   8'($urandom_range(0, 255)));
    end
    e = (bresp != 2'd0) || (bid != AXI_ID);
    if (exp_err >= 0) e = (exp_err != 0);
    exp_q.delete();
    foreach (wd[i]) exp_q.push_back(wd[i]);

    send_req(1'b1, addr, len, size);
    check({nm, "_awvalid"}, axi.awvalid, 1'b1);
    check({nm, "_awaddr"},  axi.awaddr, addr);
    check({nm, "_awlen"},   axi.awlen, len);
    check({nm, "_awsize"},  axi.awsize, size);
    check({nm, "_awburst"}, axi.awburst, 2'b01);
    check({nm, "_awid"},    axi.awid, AXI_ID);
    check({nm, "_aw_tied"}, {axi.awlock, axi.awcache, axi.awprot}, 9'd0);
    // upstream offers data early; nothing may reach W before the address phase completes
    wbeat_valid = 1'b1; wbeat_data = wd[0]; wbeat_strb = ws[0]; axi.wready = 1'b1;
    #1;
    check({nm, "_no_wvalid_in_aw"}, axi.wvalid, 1'b0);
    check({nm, "_no_wready_in_aw"}, wbeat_ready, 1'b0);
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #2;
      check({nm, "_aw_hold"}, {axi.awvalid, axi.wvalid}, 2'b10);
    end
    axi.awready = 1'b1;
    @(posedge clock); #1;
    axi.awready = 1'b0;

    b = 0;
    for (int cyc = 0; cyc < 3000 && b <= int'(len); cyc++) begin
      if (!wbeat_valid) wbeat_valid = ($urandom_range(0, stall) == 0);
      wbeat_data = wd[b]; wbeat_strb = ws[b];
      axi.wready = (stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check({nm, "_wvalid"}, axi.wvalid, wbeat_valid);
      check({nm, "_wbeat_ready"}, wbeat_ready, axi.wready);
      hs = wbeat_valid && axi.wready;
      if (wbeat_valid) check({nm, "_wlast"}, axi.wlast, (b == int'(len)));
      if (hs) begin
        check({nm, "_wdata"}, axi.wdata, exp_q.pop_front());
        check({nm, "_wstrb"}, axi.wstrb, ws[b]);
        check({nm, "_wid"}, axi.wid, AXI_ID);
      end
      @(posedge clock); #1;
      if (hs) begin
        b++;
        wbeat_valid = 1'b0;
      end
    end
    check({nm, "_w_beats"}, b, int'(len) + 1);
    wbeat_valid = 1'b0; axi.wready = 1'b0;
    #1;
    check({nm, "_bready"}, axi.bready, 1'b1);
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #2;
      check({nm, "_bwait"}, {axi.bready, done_valid}, 2'b10);
    end
    axi.bvalid = 1'b1; axi.bresp = bresp; axi.bid = bid;
    @(posedge clock); #1;
    axi.bvalid = 1'b0; axi.bresp = 2'd0; axi.bid = 4'd0;
    #1;
    check({nm, "_done_valid"}, done_valid, 1'b1);
    check({nm, "_done_err"}, done_err, e);
    check({nm, "_bready_drop"}, axi.bready, 1'b0);
    @(posedge clock); #2;
    check({nm, "_done_pulse"}, done_valid, 1'b0);
    check({nm, "_back_idle"}, req_ready, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          inj_kind;
    int          inj_beat;
    int          rmode;
    int          stall;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    logic [7:0] rl;
    logic [2:0] rsz;
    int inj, inj_b, cyc;
    string nm;

    vecs[0]  = '{0, 32'h8000_0000, 8'd0,   3'd3, 0, 0, 0, 0, 2'd0, 4'd0, 0};
    vecs[1]  = '{0, 32'h8000_0100, 8'd3,   3'd3, 0, 0, 1, 0, 2'd0, 4'd0, 0};
    vecs[2]  = '{1, 32'h8000_0200, 8'd1,   3'd3, 0, 0, 0, 0, 2'd0, 4'd0, 0};
    vecs[3]  = '{0, 32'h8000_0300, 8'd1,   3'd3, 1, 1, 0, 0, 2'd0, 4'd0, 1};
    vecs[4]  = '{0, 32'h8000_0400, 8'd1,   3'd3, 2, 0, 0, 0, 2'd0, 4'd0, 1};
    vecs[5]  = '{0, 32'h8000_0500, 8'd2,   3'd2, 4, 2, 2, 2, 2'd0, 4'd0, 1};
    vecs[6]  = '{0, 32'h8000_0600, 8'd1,   3'd1, 3, 0, 0, 1, 2'd0, 4'd0, 1};
    vecs[7]  = '{1, 32'h8000_0700, 8'd0,   3'd2, 0, 0, 0, 0, 2'd2, 4'd0, 1};
    vecs[8]  = '{1, 32'h8000_0800, 8'd2,   3'd3, 0, 0, 0, 1, 2'd0, 4'd3, 1};
    vecs[9]  = '{0, 32'h8000_0900, 8'd255, 3'd3, 0, 0, 2, 1, 2'd0, 4'd0, 0};
    vecs[10] = '{1, 32'h8000_0A00, 8'd15,  3'd0, 0, 0, 0, 2, 2'd0, 4'd0, 0};
    vecs[11] = '{0, 32'h8000_0B00, 8'd0,   3'd0, 2, 0, 0, 0, 2'd0, 4'd0, 0};

    // reset: drive upstream valids/readies high to prove they are gated off
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    wbeat_valid = 1'b1; wbeat_data = '0; wbeat_strb = '0; rbeat_ready = 1'b1;
    slave_idle();
    axi.rvalid = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, rbeat_valid}, 4'b0000);
    check("rst_readies", {axi.rready, axi.bready, wbeat_ready}, 3'b000);
    check("rst_done", {done_valid, done_err}, 2'b00);
    wbeat_valid = 1'b0; rbeat_ready = 1'b0;
    slave_idle();
    @(posedge clock); #1;
    reset = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      nm = $sformatf("vec%0d", i);
      if (vecs[i].write)
        do_write(nm, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].bresp, vecs[i].bid,
                 vecs[i].exp_err, vecs[i].stall, 1'b1);
      else
        do_read(nm, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].inj_kind, vecs[i].inj_beat,
                vecs[i].exp_err, vecs[i].rmode, vecs[i].stall, (i == 0), 64'h1122_3344_5566_7788);
    end

    // reset in the middle of write beat 0: aborted burst must vanish without a completion
    send_req(1'b1, 32'h8000_1000, 8'd3, 3'd3);
    axi.awready = 1'b1;
    @(posedge clock); #1;
    axi.awready = 1'b0;
    wbeat_valid = 1'b1; wbeat_data = 64'hDEAD_BEEF_0000_0001; wbeat_strb = 8'hFF; axi.wready = 1'b0;
    #1;
    check("rst_mid_wvalid_before", axi.wvalid, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid}, 4'b0000);
    check("rst_mid_done", {done_valid, done_err}, 2'b00);
    check("rst_mid_req_ready", req_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #2;
      check("rst_mid_no_done", done_valid, 1'b0);
    end
    check("rst_mid_idle", req_ready, 1'b1);
    wbeat_valid = 1'b0;

`ifdef AXI_MASTER_TIMEOUT_EN
    // arready held low: watchdog must close the request with an error after TIMEOUT cycles
    send_req(1'b0, 32'h8000_2000, 8'd0, 3'd3);
    cyc = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #2;
      if (done_valid) begin
        cyc = i;
        break;
      end
    end
    check("tmo_cycles", cyc, TB_TMO);
    check("tmo_err", done_err, 1'b1);
    check("tmo_arvalid", axi.arvalid, 1'b0);
    @(posedge clock); #2;
    check("tmo_pulse", done_valid, 1'b0);
`endif

    // randomized bursts checked against the reference model
    for (int i = 0; i < 24; i++) begin
      rl  = 8'($urandom_range(0, 7));
      rsz = 3'($urandom_range(0, 3));
      nm  = $sformatf("rnd%0d", i);
      if ($urandom_range(0, 1) == 1) begin
        do_write(nm, {$urandom} & 32'hFFFF_FFF8, rl, rsz,
                 ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0,
                 ($urandom_range(0, 5) == 0) ? 4'd9 : AXI_ID,
                 -1, $urandom_range(0, 2), 1'b0);
      end else begin
        inj   = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
        inj_b = $urandom_range(0, int'(rl));
        do_read(nm, {$urandom} & 32'hFFFF_FFF8, rl, rsz, inj, inj_b, -1,
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
